a_serializer: RTL and testbench

A_SERIALIZER -- requirements
Module: a_serializer

---
 rtl/a_ser_pkg.sv | 20 ++
 rtl/a_ser_sat_cnt.sv | 20 ++
 rtl/a_serializer.sv | 122 ++++++++++++
 tb/tb_a_serializer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/a_ser_pkg.sv
// rtl/a_ser_pkg.sv - shared defaults, FSM state type and frame type for a_serializer
package a_ser_pkg;

    localparam int N_DEF     = 9;
    localparam int WIDTH_DEF = 8;
    localparam int CNT_W     = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    typedef logic [N_DEF-1:0][WIDTH_DEF-1:0] frame_t;

    // Width of an element index; never zero so a single-element frame still has a port
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/a_ser_sat_cnt.sv
// rtl/a_ser_sat_cnt.sv - saturating up-counter used to count dropped frames
module a_ser_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count increment requests, sticking at all-ones instead of wrapping
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/a_serializer.sv
// rtl/a_serializer.sv - frame-to-element serializer; A_SER_DROP_CNT_EN enables the drop counter
module a_serializer
    import a_ser_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               in_valid,
    input  logic [N-1:0][WIDTH-1:0]            in_a,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [WIDTH-1:0]                   out_data,
    output logic [idx_width(N)-1:0]            out_idx,
    output logic                               out_last,
    output logic                               busy,
    output logic [CNT_W-1:0]                   drop_cnt
);

    localparam int IDX_W = idx_width(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    state_t                  state_q;
    state_t                  state_d;
    logic [N-1:0][WIDTH-1:0] frame_q;
    logic [IDX_W-1:0]        idx_q;
    logic [IDX_W-1:0]        idx_nxt;
    logic [WIDTH-1:0]        data_q;

    logic sending;
    logic at_last;
    logic hs;
    logic final_hs;
    logic capture;
    logic advance;

    // Handshake qualifiers shared by the FSM, datapath and drop counter
    always_comb begin
        sending  = (state_q == SEND);
        at_last  = (idx_q == LAST_IDX);
        hs       = sending && out_ready;
        final_hs = hs && at_last;
        // A new frame is taken when idle, or when the last element leaves this very cycle
        capture  = in_valid && (!sending || final_hs);
        advance  = hs && !at_last;
        idx_nxt  = idx_q + 1'b1;
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: stay in SEND across back-to-back frames
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (final_hs && !in_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode from state and current index
    always_comb begin
        out_valid = sending;
        busy      = sending;
        out_last  = sending && at_last;
        out_data  = data_q;
        out_idx   = idx_q;
    end

    // Frame buffer, index and registered output element; data holds when nothing moves
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_q <= '0;
            idx_q   <= '0;
            data_q  <= '0;
        end else if (capture) begin
            frame_q <= in_a;
            idx_q   <= '0;
            data_q  <= in_a[0];
        end else if (advance) begin
            idx_q   <= idx_nxt;
            data_q  <= frame_q[idx_nxt];
        end
    end

`ifdef A_SER_DROP_CNT_EN
    logic drop;

    // A frame offered while the current one is still mid-flight is discarded
    always_comb begin
        drop = in_valid && sending && !final_hs;
    end

    a_ser_sat_cnt #(
        .W(CNT_W)
    ) u_drop_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (drop),
        .count (drop_cnt)
    );
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_a_serializer.sv
// tb/tb_a_serializer.sv - self-checking bench for a_serializer against a queue-based reference
module tb_a_serializer;
    import a_ser_pkg::*;

    localparam int N     = N_DEF;
    localparam int WIDTH = WIDTH_DEF;
    localparam int IDX_W = idx_width(N);
`ifdef A_SER_DROP_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    frame_t            in_a = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [WIDTH-1:0]  out_data;
    logic [IDX_W-1:0]  out_idx;
    logic              out_last;
    logic              busy;
    logic [CNT_W-1:0]  drop_cnt;

    a_serializer #(.N(N), .WIDTH(WIDTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_a      (in_a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy),
        .drop_cnt  (drop_cnt)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] last_data = '0;
    int               drops = 0;
    bit               sent;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_drop();
        if (!CNT_EN) return 0;
        return (drops > 255) ? 255 : drops;
    endfunction

    function automatic frame_t seq_frame(input int base);
        frame_t f;
        for (int i = 0; i < N; i++) f[i] = WIDTH'(base + i);
        return f;
    endfunction

    function automatic frame_t rnd_frame();
        frame_t f;
        for (int i = 0; i < N; i++) f[i] = WIDTH'($urandom);
        return f;
    endfunction

    // Outputs must show the head of the pending-element queue, or idle with the last value
    task automatic check_outputs();
        check("out_valid", 32'(out_valid), 32'(q.size() > 0));
        check("busy", 32'(busy), 32'(q.size() > 0));
        check("drop_cnt", 32'(drop_cnt), exp_drop());
        if (q.size() > 0) begin
            check("out_data", 32'(out_data), 32'(q[0]));
            check("out_idx", 32'(out_idx), 32'(N - q.size()));
            check("out_last", 32'(out_last), 32'(q.size() == 1));
        end else begin
            check("idle_last", 32'(out_last), 32'd0);
            check("idle_data", 32'(out_data), 32'(last_data));
        end
    endtask

    // One clock: check, advance the reference model with this cycle's inputs, apply them
    task automatic cycle(input logic iv, input frame_t fa, input logic rdy);
        bit hs;
        bit accept;
        check_outputs();
        hs     = (q.size() > 0) && rdy;
        accept = 1'b0;
        if (iv) begin
            if ((q.size() == 0) || (hs && q.size() == 1)) accept = 1'b1;
            else drops++;
        end
        if (hs) begin
            last_data = q[0];
            void'(q.pop_front());
        end
        if (accept) begin
            q.delete();
            for (int i = 0; i < N; i++) q.push_back(fa[i]);
        end
        in_valid  = iv;
        in_a      = fa;
        out_ready = rdy;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, rdy);
    endtask

    // Assert reset between clock edges and confirm outputs clear before the next edge
    task automatic async_reset(input int hold);
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        q.delete();
        last_data = '0;
        drops = 0;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_idx", 32'(out_idx), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);
        for (int i = 0; i < hold; i++) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        // Power-on reset
        #1;
        check("por_valid", 32'(out_valid), 32'd0);
        check("por_data", 32'(out_data), 32'd0);
        check("por_drop", 32'(drop_cnt), 32'd0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Frame accepted in the first cycle after release, full-rate drain
        cycle(1'b1, seq_frame(100), 1'b1);
        idle(N + 2, 1'b1);

        // Alternating ready: each element holds while ready is low
        cycle(1'b1, seq_frame(100), 1'b1);
        for (int k = 0; k < 2 * N + 2; k++) cycle(1'b0, '0, (k % 2) == 0);
        idle(2, 1'b1);

        // Back-to-back frame offered during the final handshake
        cycle(1'b1, seq_frame(100), 1'b1);
        sent = 1'b0;
        for (int k = 0; k < N + 2; k++) begin
            if (!sent && q.size() == 1) begin
                sent = 1'b1;
                cycle(1'b1, seq_frame(200), 1'b1);
            end else begin
                cycle(1'b0, '0, 1'b1);
            end
        end
        idle(N + 2, 1'b1);

        // Frame offered at idx 3 is dropped, stream continues
        cycle(1'b1, seq_frame(100), 1'b1);
        for (int k = 0; k < N + 2; k++) begin
            if (q.size() == N - 3) cycle(1'b1, seq_frame(200), 1'b1);
            else cycle(1'b0, '0, 1'b1);
        end
        idle(2, 1'b1);

        // 300 drops saturate the counter
        cycle(1'b1, seq_frame(10), 1'b0);
        for (int k = 0; k < 300; k++) cycle(1'b1, seq_frame(20), 1'b0);
        check("drop_sat", 32'(drop_cnt), CNT_EN ? 32'd255 : 32'd0);
        idle(N + 2, 1'b1);

        // Reset at idx 5, no output until the next frame
        cycle(1'b1, seq_frame(100), 1'b1);
        for (int k = 0; k < N && q.size() > N - 5; k++) cycle(1'b0, '0, 1'b1);
        check("at_idx5", 32'(out_idx), 32'd5);
        async_reset(2);
        idle(4, 1'b1);
        cycle(1'b1, seq_frame(50), 1'b1);
        check("first_50", 32'(out_data), 32'd50);
        idle(N + 2, 1'b1);

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            if (($urandom % 4) == 0) cycle(1'b1, rnd_frame(), ($urandom % 3) != 0);
            else cycle(1'b0, '0, ($urandom % 3) != 0);
        end
        idle(3 * N, 1'b1);
        check_outputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
